menu_frame_scanner: RTL and testbench



---
 rtl/snake_vga_pkg.sv | 13 +
 rtl/menu_frame_scanner_raster_counter.sv | 36 +++
 rtl/menu_frame_scanner.sv | 97 +++++++++
 tb/tb_menu_frame_scanner.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/snake_vga_pkg.sv
// snake_vga_pkg: shared VGA geometry, colours and menu scanner states
package snake_vga_pkg;
    localparam int H_RES    = 160;
    localparam int V_RES    = 120;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam logic [COLOUR_W-1:0] BLACK     = 3'b000;
    localparam logic [COLOUR_W-1:0] WHITE     = 3'b111;
    localparam logic [COLOUR_W-1:0] FG_COLOUR = WHITE;
    localparam logic [COLOUR_W-1:0] BG_COLOUR = BLACK;
    typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} scan_state_e;
endpackage

// File: rtl/menu_frame_scanner_raster_counter.sv
// raster_counter: x/y raster position with row wrap and end-of-frame flag
module raster_counter
    import snake_vga_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           clear,
    input  logic           advance,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);
    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic           x_end, y_end;
    // next position: x wraps at the line end, y steps only on that wrap
    always_comb begin
        x_end = x_q == X_W'(H_RES - 1);
        y_end = y_q == Y_W'(V_RES - 1);
        x_d   = clear ? '0 : !advance ? x_q : x_end ? '0 : x_q + X_W'(1);
        y_d   = clear ? '0 : !(advance && x_end) ? y_q : y_end ? '0 : y_q + Y_W'(1);
    end
    // position register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end
    assign x    = x_q;
    assign y    = y_q;
    assign last = x_end && y_end;
endmodule

// File: rtl/menu_frame_scanner.sv
// menu_frame_scanner: raster-scans the menu screen through the text responder into VGA writes
module menu_frame_scanner
    import snake_vga_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                inmenu,
    output logic [X_W-1:0]      x_pointer,
    output logic [Y_W-1:0]      y_pointer,
    input  logic                menu_text,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot,
    output logic                busy,
    output logic                done
);
    scan_state_e         state_q, state_d;
    logic                flush_q, flush_d;
    logic                scanning, last;
    logic                s1_v_q;
    logic [X_W-1:0]      s1_x_q, vga_x_q;
    logic [Y_W-1:0]      s1_y_q, vga_y_q;
    logic [COLOUR_W-1:0] vga_colour_q;
    logic                vga_plot_q;

    assign scanning = state_q == SCAN;

    raster_counter u_raster (
        .clk     (clk),
        .reset   (reset),
        .clear   (scanning && last),
        .advance (scanning),
        .x       (x_pointer),
        .y       (y_pointer),
        .last    (last)
    );

    // next state: scan until the last pixel is presented, drain two cycles, pulse done
    always_comb begin
        state_d = state_q;
        flush_d = 1'b0;
        case (state_q)
            IDLE:    state_d = start ? SCAN : IDLE;
            SCAN:    state_d = last ? FLUSH : SCAN;
            FLUSH: begin
                flush_d = !flush_q;
                state_d = flush_q ? DONE : FLUSH;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state and flush-cycle registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            flush_q <= flush_d;
        end
    end

    // stage 1 shadows the responder's register; stage 2 forms the VGA write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v_q       <= 1'b0;
            s1_x_q       <= '0;
            s1_y_q       <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= BG_COLOUR;
            vga_plot_q   <= 1'b0;
        end else begin
            s1_v_q       <= scanning;
            s1_x_q       <= x_pointer;
            s1_y_q       <= y_pointer;
            vga_plot_q   <= s1_v_q;
            vga_colour_q <= (s1_v_q && menu_text) ? FG_COLOUR : BG_COLOUR;
            if (s1_v_q) begin
                vga_x_q <= s1_x_q;
                vga_y_q <= s1_y_q;
            end
        end
    end

    assign inmenu     = scanning;
    assign busy       = scanning || state_q == FLUSH;
    assign done       = state_q == DONE;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
endmodule

// File: tb/tb_menu_frame_scanner.sv
// tb_menu_frame_scanner: directed frame scans against a registered responder stub
module tb_menu_frame_scanner;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       inmenu, menu_text, vga_plot, busy, done;
    logic [7:0] x_pointer, vga_x;
    logic [6:0] y_pointer, vga_y;
    logic [2:0] vga_colour;
    int         errors = 0;
    int         checks = 0;

    typedef struct {
        int         x;
        int         y;
        logic [2:0] col;
    } pt_t;
    pt_t tab[6];

    menu_frame_scanner dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .inmenu     (inmenu),
        .x_pointer  (x_pointer),
        .y_pointer  (y_pointer),
        .menu_text  (menu_text),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic text_at(input int x, input int y);
        return (x >= 8 && x <= 16 && y >= 8 && y <= 20) ||
               (x >= 40 && x <= 50 && y >= 50 && y <= 60) ||
               (((x ^ y) & 7) == 5);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) menu_text <= 1'b0;
        else if (inmenu) menu_text <= text_at(int'(x_pointer), int'(y_pointer));
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input int pulse_at, input bit pulse_done, input int rst_at, input bit check_pts);
        int pc = 0, pl = 0, first_plot = -1, last_plot = -1, done_cnt = 0, done_at = -1;
        int ptr_err = 0, plot_err = 0, col_err = 0, hold_err = 0, busy_err = 0, max_x = 0, max_y = 0;
        int ex, ey;
        logic [7:0] lx = '0;
        logic [6:0] ly = '0;
        bit fin = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_inmenu", 32'(inmenu), 1);
        check("start_ptr", 32'({x_pointer, y_pointer}), 0);
        for (int c = 0; c < 19300 && !fin; c++) begin
            if (c > 0) @(negedge clk);
            start = (c == pulse_at) || (pulse_done && done);
            if (c == rst_at) begin
                reset = 1'b1;
                #1;
                check("reset_ptr_outs", 32'({inmenu, x_pointer, y_pointer, busy, done}), 0);
                check("reset_vga_outs", 32'({vga_x, vga_y, vga_colour, vga_plot}), 0);
                check("reset_no_done", 32'(done_cnt), 0);
                @(negedge clk) reset = 1'b0;
                start = 1'b0;
                return;
            end
            if (pc < 19200) begin
                if (!inmenu || int'(x_pointer) != pc % 160 || int'(y_pointer) != pc / 160) ptr_err++;
                pc++;
            end else if (pc == 19200) begin
                check("wrap_end_ptr", 32'({inmenu, x_pointer, y_pointer}), 0);
                pc++;
            end else if (inmenu) ptr_err++;
            if (c == 159) check("wrap_row_pre", 32'({x_pointer, y_pointer}), 32'({8'd159, 7'd0}));
            if (c == 160) check("wrap_row_post", 32'({x_pointer, y_pointer}), 32'({8'd0, 7'd1}));
            if (vga_plot) begin
                if (first_plot < 0) first_plot = c;
                last_plot = c;
                ex = pl % 160;
                ey = pl / 160;
                if (c != pl + 2) plot_err++;
                if (int'(vga_x) != ex || int'(vga_y) != ey) plot_err++;
                if (vga_colour !== (text_at(ex, ey) ? 3'b111 : 3'b000)) col_err++;
                if (check_pts)
                    for (int i = 0; i < 6; i++)
                        if (tab[i].x == ex && tab[i].y == ey)
                            check($sformatf("colour(%0d,%0d)", ex, ey), 32'(vga_colour), 32'(tab[i].col));
                if (int'(vga_x) > max_x) max_x = int'(vga_x);
                if (int'(vga_y) > max_y) max_y = int'(vga_y);
                lx = vga_x;
                ly = vga_y;
                pl++;
            end else if (vga_colour !== 3'b000 || (pl > 0 && (vga_x !== lx || vga_y !== ly))) hold_err++;
            if (busy === done) busy_err++;
            if (done) begin
                done_cnt++;
                done_at = c;
                fin = 1;
            end
        end
        @(negedge clk) start = 1'b0;
        check("plot_count", 32'(pl), 19200);
        check("first_plot_cycle", 32'(first_plot), 2);
        check("last_plot_cycle", 32'(last_plot), 19201);
        check("done_count", 32'(done_cnt), 1);
        check("done_cycle", 32'(done_at), 19202);
        check("ptr_seq_errs", 32'(ptr_err), 0);
        check("plot_seq_errs", 32'(plot_err), 0);
        check("colour_errs", 32'(col_err), 0);
        check("idle_hold_errs", 32'(hold_err), 0);
        check("busy_done_errs", 32'(busy_err), 0);
        check("max_vga_x", 32'(max_x), 159);
        check("max_vga_y", 32'(max_y), 119);
        for (int i = 0; i < 4; i++) begin
            check("post_done_idle", 32'({inmenu, busy, done, vga_plot}), 0);
            @(negedge clk);
        end
    endtask

    initial begin
        int idle_err = 0;
        tab[0] = '{10, 11, 3'b111};
        tab[1] = '{0, 0, 3'b000};
        tab[2] = '{37, 11, 3'b000};
        tab[3] = '{41, 54, 3'b111};
        tab[4] = '{5, 0, 3'b111};
        tab[5] = '{159, 119, 3'b000};
        repeat (3) @(negedge clk);
        check("reset_state", 32'({inmenu, x_pointer, y_pointer, busy, done}), 0);
        check("reset_vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({inmenu, x_pointer, y_pointer, busy, done, vga_x, vga_y, vga_colour, vga_plot} !== '0) idle_err++;
        end
        check("idle_no_start", 32'(idle_err), 0);
        run_frame(-1, 0, -1, 1);
        run_frame(5000, 1, -1, 0);
        run_frame(-1, 0, 7000, 0);
        run_frame(-1, 0, -1, 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
